// File: rtl/fft_bin_sequencer_if.sv
// Bundle of the FFT-side, RAM-side and result-side signals of the post-FFT
// bin sequencer.
//   master : the sequencer (drives RAM address/data/we, fft_ready, results)
//   slave  : the environment (FFT core, I/Q RAMs, result consumer)
// Signals:
//   fft_out_data/Iout/Qout/fft_ready          FFT sample stream
//   ram_addr/ram_we/ram_wdata_*/ram_rdata_*   shared I/Q buffer RAM port
//   pdb_ack/AC_component/DC_component/ac_bin/
//   new_comp_DV/pdb_done/overrun               result hand-off and status
interface fft_bin_sequencer_if #(
  parameter int ADDR_W = 11
);
  logic                     fft_out_data;
  logic signed [23:0]       Iout;
  logic signed [23:0]       Qout;
  logic                     fft_ready;
  logic [ADDR_W-1:0]        ram_addr;
  logic                     ram_we;
  logic [23:0]              ram_wdata_i;
  logic [23:0]              ram_wdata_q;
  logic [23:0]              ram_rdata_i;
  logic [23:0]              ram_rdata_q;
  logic                     pdb_ack;
  logic [21:0]              AC_component;
  logic [21:0]              DC_component;
  logic [ADDR_W-1:0]        ac_bin;
  logic                     new_comp_DV;
  logic                     pdb_done;
  logic                     overrun;

  modport master (
    input  fft_out_data, Iout, Qout, ram_rdata_i, ram_rdata_q, pdb_ack,
    output fft_ready, ram_addr, ram_we, ram_wdata_i, ram_wdata_q,
           AC_component, DC_component, ac_bin, new_comp_DV, pdb_done, overrun
  );

  modport slave (
    output fft_out_data, Iout, Qout, ram_rdata_i, ram_rdata_q, pdb_ack,
    input  fft_ready, ram_addr, ram_we, ram_wdata_i, ram_wdata_q,
           AC_component, DC_component, ac_bin, new_comp_DV, pdb_done, overrun
  );
endinterface

// File: rtl/fft_bin_sequencer.sv
// Post-FFT buffer controller. Captures one frame of N_POINTS I/Q bins into
// the shared I and Q RAMs, then reuses the same RAM port to read bins
// 0..AC_HI_BIN back, forms |I|+|Q| (saturated to 22 bits) per bin, keeps the
// bin-0 magnitude as DC and the strongest bin in AC_LO_BIN..AC_HI_BIN as AC,
// and publishes both with a one-cycle new_comp_DV pulse. The result is held
// (pdb_done) until pdb_ack.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous reset, active HIGH despite the name
//   bus      fft_bin_sequencer_if.master (FFT stream, RAM port, results)
// ram_we/ram_addr/ram_wdata_* are combinational; all other outputs are
// registered.
module fft_bin_sequencer #(
  parameter int N_POINTS  = 2048,
  parameter int ADDR_W    = 11,
  parameter int AC_LO_BIN = 1,
  parameter int AC_HI_BIN = 1023,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fft_bin_sequencer_if.master  bus
);

  // One extra bit so the read cycle counter can run past the last address
  // while the final RD_LAT returns drain.
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] LAST_WR     = ADDR_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0]  LAST_ISSUE  = CNT_W'(AC_HI_BIN);
  localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(AC_HI_BIN + RD_LAT);
  localparam logic [CNT_W-1:0]  LAT         = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0]  LO_BIN      = CNT_W'(AC_LO_BIN);
  localparam logic [CNT_W-1:0]  HI_BIN      = CNT_W'(AC_HI_BIN);
  localparam logic [ADDR_W-1:0] LO_BIN_A    = ADDR_W'(AC_LO_BIN);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    READ,
    FINISH,
    HOLD
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]    rd_cyc;
  logic [21:0]         max_mag;
  logic [ADDR_W-1:0]   max_bin;
  logic [21:0]         dc_mag;

  logic                fft_ready_r;
  logic [21:0]         ac_r;
  logic [21:0]         dc_r;
  logic [ADDR_W-1:0]   ac_bin_r;
  logic                dv_r;
  logic                done_r;
  logic                overrun_r;

  logic                accept;
  logic                sample_en;
  logic [CNT_W-1:0]    samp_bin;
  logic [23:0]         abs_i;
  logic [23:0]         abs_q;
  logic [24:0]         mag_sum;
  logic [21:0]         mag_sat;
  logic [ADDR_W-1:0]   addr_mux;

  always_comb begin
    accept    = bus.fft_out_data && fft_ready_r &&
                ((state == IDLE) || (state == CAPTURE));
    // rd_cyc counts READ cycles; the return for address k lands RD_LAT
    // cycles after it was issued, so the bin being sampled trails rd_cyc.
    sample_en = (state == READ) && (rd_cyc >= LAT);
    samp_bin  = rd_cyc - LAT;

    abs_i   = bus.ram_rdata_i[23] ? (~bus.ram_rdata_i + 24'd1) : bus.ram_rdata_i;
    abs_q   = bus.ram_rdata_q[23] ? (~bus.ram_rdata_q + 24'd1) : bus.ram_rdata_q;
    mag_sum = {1'b0, abs_i} + {1'b0, abs_q};
    mag_sat = (|mag_sum[24:22]) ? '1 : mag_sum[21:0];

    addr_mux = wr_cnt;
    if (state == READ) begin
      addr_mux = (rd_cyc <= LAST_ISSUE) ? rd_cyc[ADDR_W-1:0] : LAST_ISSUE[ADDR_W-1:0];
    end
  end

  assign bus.ram_we       = accept;
  assign bus.ram_addr     = addr_mux;
  assign bus.ram_wdata_i  = bus.Iout;
  assign bus.ram_wdata_q  = bus.Qout;

  assign bus.fft_ready    = fft_ready_r;
  assign bus.AC_component = ac_r;
  assign bus.DC_component = dc_r;
  assign bus.ac_bin       = ac_bin_r;
  assign bus.new_comp_DV  = dv_r;
  assign bus.pdb_done     = done_r;
  assign bus.overrun      = overrun_r;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cyc      <= '0;
      max_mag     <= '0;
      max_bin     <= LO_BIN_A;
      dc_mag      <= '0;
      fft_ready_r <= 1'b1;
      ac_r        <= '0;
      dc_r        <= '0;
      ac_bin_r    <= '0;
      dv_r        <= 1'b0;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      dv_r <= 1'b0;
      if (bus.fft_out_data && !fft_ready_r) begin
        overrun_r <= 1'b1;
      end

      case (state)
        IDLE, CAPTURE: begin
          if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            state  <= CAPTURE;
            if (wr_cnt == LAST_WR) begin
              // Frame complete: arm the read-back scan with fresh extrema.
              state       <= READ;
              fft_ready_r <= 1'b0;
              wr_cnt      <= '0;
              rd_cyc      <= '0;
              max_mag     <= '0;
              max_bin     <= LO_BIN_A;
              dc_mag      <= '0;
            end
          end
        end

        READ: begin
          rd_cyc <= rd_cyc + 1'b1;
          if (sample_en) begin
            if (samp_bin == '0) begin
              dc_mag <= mag_sat;
            end
            // Strict compare: on ties the earlier (lower) bin is kept.
            if ((samp_bin >= LO_BIN) && (samp_bin <= HI_BIN) && (mag_sat > max_mag)) begin
              max_mag <= mag_sat;
              max_bin <= samp_bin[ADDR_W-1:0];
            end
          end
          if (rd_cyc == LAST_SAMPLE) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          ac_r     <= max_mag;
          dc_r     <= dc_mag;
          ac_bin_r <= max_bin;
          dv_r     <= 1'b1;
          done_r   <= 1'b1;
          state    <= HOLD;
        end

        HOLD: begin
          if (bus.pdb_ack) begin
            done_r      <= 1'b0;
            fft_ready_r <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
